// File: rtl/bpsk_carrier_modulator.sv
// rtl/bpsk_carrier_modulator.sv - BPSK modulator: symbol hold, quarter-wave LUT NCO, 2-stage multiply/saturate
module bpsk_carrier_modulator #(
  parameter int SPS         = 16,
  parameter int PHASE_W     = 16,
  parameter int CARRIER_FCW = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic signed [7:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic signed [7:0] mod_out,
  output logic              mod_valid,
  output logic              underrun
);

  localparam int CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPS - 1);
  localparam logic [PHASE_W-1:0] FCW      = PHASE_W'(CARRIER_FCW);

  // First quadrant of round(127*sin(2*pi*a/256)), a = 0..64
  localparam logic [6:0] ROM [65] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

  logic [PHASE_W-1:0] phase_acc;
  logic [CNT_W-1:0]   sym_cnt;
  logic signed [7:0]  symbol;
  logic signed [7:0]  sine_r;
  logic signed [7:0]  sym_r;
  logic [1:0]         fill;

  logic [7:0]         idx;
  logic [1:0]         quad;
  logic [5:0]         offs;
  logic [6:0]         rom_addr;
  logic signed [7:0]  rom_s;
  logic signed [7:0]  lut_val;
  logic signed [15:0] prod;
  logic signed [7:0]  sat_val;

  assign idx      = phase_acc[PHASE_W-1 -: 8];
  assign quad     = idx[7:6];
  assign offs     = idx[5:0];
  // Odd quadrants read the table mirrored; the upper half negates it
  assign rom_addr = quad[0] ? (7'd64 - {1'b0, offs}) : {1'b0, offs};
  assign rom_s    = $signed({1'b0, ROM[rom_addr]});
  assign lut_val  = quad[1] ? (8'sd0 - rom_s) : rom_s;

  assign prod    = 16'(sine_r) * 16'(sym_r);
  assign sat_val = (prod > 16'sd127)  ? 8'sd127 :
                   (prod < -16'sd127) ? -8'sd127 : prod[7:0];

  assign data_ready = enable && (sym_cnt == CNT_LAST);
  assign mod_valid  = enable && fill[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_acc <= '0;
      sym_cnt   <= '0;
      symbol    <= '0;
      sine_r    <= '0;
      sym_r     <= '0;
      mod_out   <= '0;
      fill      <= '0;
      underrun  <= 1'b0;
    end else if (enable) begin
      phase_acc <= phase_acc + FCW;
      sym_cnt   <= (sym_cnt == CNT_LAST) ? '0 : sym_cnt + 1'b1;
      if (data_ready) begin
        if (data_valid) begin
          symbol <= data_in;
        end else begin
          symbol   <= '0;
          underrun <= 1'b1;
        end
      end
      sine_r  <= lut_val;
      sym_r   <= symbol;
      mod_out <= sat_val;
      if (!fill[1]) fill <= fill + 2'd1;
    end
  end

endmodule

// File: tb/tb_bpsk_carrier_modulator.sv
// tb/tb_bpsk_carrier_modulator.sv - scoreboard bench for bpsk_carrier_modulator
module tb_bpsk_carrier_modulator;

  localparam int SPS = 16;
  localparam int FCW = 4096;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              data_valid = 1'b0;
  logic [7:0]        data_in = 8'h00;
  logic              data_ready;
  logic signed [7:0] mod_out;
  logic              mod_valid;
  logic              underrun;

  logic              rst_w = 1'b0;
  logic              en_w = 1'b0;
  logic              rdy_w;
  logic signed [7:0] mod_w;
  logic              mv_w;
  logic              un_w;

  bpsk_carrier_modulator dut (
    .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .mod_out(mod_out),
    .mod_valid(mod_valid), .underrun(underrun)
  );

  bpsk_carrier_modulator #(.SPS(16), .PHASE_W(16), .CARRIER_FCW(65535)) dut_w (
    .clock(clock), .reset(rst_w), .enable(en_w), .data_in(8'sh01),
    .data_valid(1'b1), .data_ready(rdy_w), .mod_out(mod_w),
    .mod_valid(mv_w), .underrun(un_w)
  );

  always #5 clock = ~clock;

  int                n_checks = 0;
  int                n_pass = 0;
  logic [15:0]       m_phase;
  int                m_cnt;
  int                m_fill;
  logic signed [7:0] m_symbol;
  logic              m_under;
  int                sb[$];

  function automatic int rom(input int a);
    real r;
    r = 127.0 * $sin(6.283185307179586 * a / 256.0);
    return $rtoi(r + 0.5);
  endfunction

  function automatic int lut(input logic [7:0] ix);
    int i;
    i = int'(ix[5:0]);
    case (ix[7:6])
      2'd0:    return rom(i);
      2'd1:    return rom(64 - i);
      2'd2:    return -rom(i);
      default: return -rom(64 - i);
    endcase
  endfunction

  function automatic int sat(input int p);
    if (p > 127) return 127;
    if (p < -127) return -127;
    return p;
  endfunction

  task automatic model_reset();
    m_phase = '0; m_cnt = 0; m_fill = 0; m_symbol = '0; m_under = 1'b0;
    sb.delete();
  endtask

  task automatic step(input logic en, input logic dv, input logic [7:0] din, output logic rdy);
    logic exp_rdy;
    logic signed [7:0] e8;
    enable = en; data_valid = dv; data_in = din;
    #1;
    exp_rdy = en && (m_cnt == SPS - 1);
    rdy = data_ready;
    n_checks++;
    if (data_ready !== exp_rdy) $display("FAIL data_ready: got %b want %b", data_ready, exp_rdy);
    else n_pass++;
    if (en) sb.push_back(sat(lut(m_phase[15:8]) * int'(m_symbol)));
    @(posedge clock); #1;
    if (en) begin
      m_phase = m_phase + 16'(FCW);
      if (exp_rdy) begin
        if (dv) m_symbol = din;
        else begin m_symbol = '0; m_under = 1'b1; end
      end
      m_cnt = (m_cnt == SPS - 1) ? 0 : m_cnt + 1;
      if (m_fill < 2) m_fill++;
      if (sb.size() == 2) begin
        e8 = 8'(sb.pop_front());
        n_checks++;
        if (mod_out !== e8) $display("FAIL mod_out: got %0d want %0d", mod_out, e8);
        else n_pass++;
      end
    end
    n_checks++;
    if (mod_valid !== (en && m_fill == 2)) $display("FAIL mod_valid: got %b want %b", mod_valid, en && m_fill == 2);
    else n_pass++;
    n_checks++;
    if (underrun !== m_under) $display("FAIL underrun: got %b want %b", underrun, m_under);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({mod_out, mod_valid, data_ready, underrun} !== 11'd0)
      $display("FAIL reset_outputs: got %h want 0", {mod_out, mod_valid, data_ready, underrun});
    else n_pass++;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_carrier();
    int tbl [16] = '{0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49};
    logic rdy;
    logic signed [7:0] t8;
    for (int k = 0; k < 48; k++) begin
      step(1'b1, 1'b1, 8'h01, rdy);
      n_checks++;
      if (rdy !== ((k % 16) == 15)) $display("FAIL ready_cadence: clk %0d got %b", k + 1, rdy);
      else n_pass++;
      if (k >= 17) begin
        t8 = 8'(tbl[(k - 17) % 16]);
        n_checks++;
        if (mod_out !== t8) $display("FAIL carrier_table: got %0d want %0d", mod_out, t8);
        else n_pass++;
      end
    end
  endtask

  task automatic test_alternating();
    logic rdy;
    for (int k = 0; k < 64; k++)
      step(1'b1, 1'b1, ((k / 16) % 2 == 1) ? 8'hFF : 8'h01, rdy);
  endtask

  task automatic test_underrun();
    logic rdy;
    n_checks++;
    if (underrun !== 1'b0) $display("FAIL underrun_pre: got %b want 0", underrun);
    else n_pass++;
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 8'h01, rdy);
    for (int k = 0; k < 36; k++) step(1'b1, 1'b1, 8'hFF, rdy);
    n_checks++;
    if (underrun !== 1'b1) $display("FAIL underrun_sticky: got %b want 1", underrun);
    else n_pass++;
  endtask

  task automatic test_enable_gap();
    logic rdy;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 8'h01, rdy);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'hFF, rdy);
    for (int k = 0; k < 24; k++) step(1'b1, 1'b1, 8'hFF, rdy);
  endtask

  task automatic test_saturation();
    logic rdy;
    for (int k = 0; k < 40; k++) step(1'b1, 1'b1, 8'h80, rdy);
  endtask

  task automatic test_async_reset();
    logic rdy;
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 8'h01, rdy);
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({mod_out, mod_valid, data_ready, underrun} !== 11'd0)
      $display("FAIL async_reset: got %h want 0", {mod_out, mod_valid, data_ready, underrun});
    else n_pass++;
    #3 reset = 1'b1;
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 8'h01, rdy);
  endtask

  task automatic test_wrap();
    logic [15:0] pw;
    logic signed [7:0] sw;
    logic signed [7:0] e8;
    int cw;
    int q2[$];
    logic exp_rdy;
    pw = '0; sw = '0; cw = 0;
    enable = 1'b0;
    rst_w = 1'b1;
    for (int k = 0; k < 40; k++) begin
      en_w = 1'b1;
      #1;
      exp_rdy = (cw == SPS - 1);
      n_checks++;
      if (rdy_w !== exp_rdy) $display("FAIL wrap_ready: got %b want %b", rdy_w, exp_rdy);
      else n_pass++;
      q2.push_back(sat(lut(pw[15:8]) * int'(sw)));
      @(posedge clock); #1;
      if (exp_rdy) sw = 8'sh01;
      cw = (cw == SPS - 1) ? 0 : cw + 1;
      pw = pw + 16'hFFFF;
      if (q2.size() == 2) begin
        e8 = 8'(q2.pop_front());
        n_checks++;
        if (mod_w !== e8) $display("FAIL wrap_mod_out: got %0d want %0d", mod_w, e8);
        else n_pass++;
      end
    end
    n_checks++;
    if (mod_w !== -8'sd3) $display("FAIL wrap_q3_i63: got %0d want -3", mod_w);
    else n_pass++;
    n_checks++;
    if ($isunknown({mod_w, mv_w, un_w}) || mv_w !== 1'b1)
      $display("FAIL wrap_valid: got %b/%h want 1/known", mv_w, mod_w);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_carrier();
    test_alternating();
    test_underrun();
    test_enable_gap();
    test_saturation();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
